vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 tb/tb_vga_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Pixel-strobe divider, h/v position counters and registered
//            sync/blank/colour pipeline for a 640x480 style raster.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic [5:0] rgb_in,
  output logic       pix_stb,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [5:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0]       c_h_last   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       c_v_last   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       c_h_act    = 10'(H_ACTIVE);
  localparam logic [9:0]       c_v_act    = 10'(V_ACTIVE);
  localparam logic [9:0]       c_hs_beg   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]       c_vs_beg   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             stb_q, stb_d;
  logic [9:0]       hpos_q, hpos_d;
  logic [9:0]       vpos_q, vpos_d;
  logic             line_q, line_d;
  logic             fstart_q, fstart_d;
  logic [7:0]       frame_q, frame_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [5:0]       rgb_q, rgb_d;

  logic w_h_wrap, w_v_wrap, w_de;

  // Strobe is registered from the next divider value so it is high exactly
  // while div_q == PIX_DIV-1 and is cleanly low during reset.
  always_comb begin
    div_d    = (div_q == c_div_last) ? '0 : div_q + DIV_W'(1);
    stb_d    = (div_d == c_div_last);
    w_h_wrap = (hpos_q == c_h_last);
    w_v_wrap = (vpos_q == c_v_last);
    w_de     = (hpos_q < c_h_act) && (vpos_q < c_v_act);

    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    frame_d  = frame_q;
    line_d   = 1'b0;
    fstart_d = 1'b0;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    de_d     = de_q;
    rgb_d    = rgb_q;

    if (stb_q) begin
      hpos_d = w_h_wrap ? '0 : hpos_q + 10'd1;
      if (w_h_wrap) begin
        line_d = 1'b1;
        vpos_d = w_v_wrap ? '0 : vpos_q + 10'd1;
        if (w_v_wrap) begin
          fstart_d = 1'b1;
          frame_d  = frame_q + 8'd1;
        end
      end
      // Pipeline describes the pixel at the pre-increment position.
      de_d    = w_de;
      hsync_d = !((hpos_q >= c_hs_beg) && (hpos_q < c_hs_end));
      vsync_d = !((vpos_q >= c_vs_beg) && (vpos_q < c_vs_end));
      rgb_d   = w_de ? rgb_in : '0;
    end
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      stb_q    <= 1'b0;
      hpos_q   <= '0;
      vpos_q   <= '0;
      line_q   <= 1'b0;
      fstart_q <= 1'b0;
      frame_q  <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      de_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      div_q    <= div_d;
      stb_q    <= stb_d;
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      line_q   <= line_d;
      fstart_q <= fstart_d;
      frame_q  <= frame_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      rgb_q    <= rgb_d;
    end
  end

  assign pix_stb     = stb_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign line_start  = line_q;
  assign frame_start = fstart_q;
  assign frame       = frame_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb_out     = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed self-checking bench: full-size instance for pixel/line
//            timing, reduced-size PIX_DIV=1 instance for frame-level timing.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_s;
  logic [5:0] rgb_in, rgb_in_s;

  logic       pix_stb, line_start, frame_start, hsync, vsync, de;
  logic [9:0] hpos, vpos;
  logic [7:0] frame;
  logic [5:0] rgb_out;

  logic       pix_stb_s, line_start_s, frame_start_s, hsync_s, vsync_s, de_s;
  logic [9:0] hpos_s, vpos_s;
  logic [7:0] frame_s;
  logic [5:0] rgb_out_s;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  int c_rel;
  int c_rel_s;

  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen dut (
    .clk48(clk), .rst(rst), .rgb_in(rgb_in), .pix_stb(pix_stb),
    .hpos(hpos), .vpos(vpos), .line_start(line_start),
    .frame_start(frame_start), .frame(frame), .hsync(hsync),
    .vsync(vsync), .de(de), .rgb_out(rgb_out)
  );

  // Small raster: 16 px x 10 lines, hsync px 10..12, vsync lines 7..8.
  vga_timing_gen #(
    .PIX_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk48(clk), .rst(rst_s), .rgb_in(rgb_in_s), .pix_stb(pix_stb_s),
    .hpos(hpos_s), .vpos(vpos_s), .line_start(line_start_s),
    .frame_start(frame_start_s), .frame(frame_s), .hsync(hsync_s),
    .vsync(vsync_s), .de(de_s), .rgb_out(rgb_out_s)
  );

  task automatic wait_line(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (line_start === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fs_s(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (frame_start_s === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_s = 1'b1; rgb_in = 6'h3F; rgb_in_s = 6'h3F;
    repeat (3) @(negedge clk);
    total++;
    if ({pix_stb, line_start, frame_start, hsync, vsync, de} !== 6'b000110) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 000110",
               {pix_stb, line_start, frame_start, hsync, vsync, de});
    end
    total++;
    if ({hpos, vpos, frame, rgb_out} !== 34'd0) begin
      bad++;
      $display("FAIL reset_cnt: hpos=%0d vpos=%0d frame=%0d rgb=%h want all 0",
               hpos, vpos, frame, rgb_out);
    end
    total++;
    if ({pix_stb_s, line_start_s, frame_start_s, hsync_s, vsync_s, de_s,
         hpos_s, vpos_s, frame_s, rgb_out_s} !== {6'b000110, 34'd0}) begin
      bad++;
      $display("FAIL reset_small: stb=%b hs=%b vs=%b de=%b hpos=%0d vpos=%0d",
               pix_stb_s, hsync_s, vsync_s, de_s, hpos_s, vpos_s);
    end
  endtask

  task automatic test_strobe();
    rgb_in = 6'h2A;
    @(negedge clk);
    rst   = 1'b0;
    c_rel = cyc;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (pix_stb !== 1'(k % 2)) begin
        bad++;
        $display("FAIL strobe_k%0d: got %b want %b", k, pix_stb, 1'(k % 2));
      end
      total++;
      if (hpos !== 10'(k / 2)) begin
        bad++;
        $display("FAIL hpos_k%0d: got %0d want %0d", k, hpos, k / 2);
      end
    end
    total++;
    if ({de, hsync, vsync, rgb_out} !== {3'b111, 6'h2A}) begin
      bad++;
      $display("FAIL first_pixel: de=%b hs=%b vs=%b rgb=%h want 1 1 1 2a",
               de, hsync, vsync, rgb_out);
    end
  endtask

  task automatic test_line();
    bit ok;
    int c0, hs_low, rgb_hi, blank_err, fall_hpos, fall_stb, p;
    logic hs_prev;
    logic [5:0] exp_rgb;
    rgb_in = 6'h3F;
    wait_line(2000, ok);
    total++;
    if (!ok || (cyc - c_rel) != 1600) begin
      bad++;
      $display("FAIL first_line_start: ok=%0d at cycle %0d want 1600", ok, cyc - c_rel);
    end
    total++;
    if (hpos !== 10'd0 || vpos !== 10'd1) begin
      bad++;
      $display("FAIL line_wrap_pos: hpos=%0d vpos=%0d want 0 1", hpos, vpos);
    end
    c0 = cyc; hs_low = 0; rgb_hi = 0; blank_err = 0;
    fall_hpos = -1; fall_stb = -1; hs_prev = hsync; ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      p = (hpos == 10'd0) ? 799 : int'(hpos) - 1;
      exp_rgb = (p < 640) ? 6'h3F : 6'h00;
      if (rgb_out !== exp_rgb || de !== (p < 640)) blank_err++;
      if (rgb_out === 6'h3F) rgb_hi++;
      if (hsync === 1'b0) hs_low++;
      if (hs_prev === 1'b1 && hsync === 1'b0) begin
        fall_hpos = int'(hpos); fall_stb = int'(pix_stb);
      end
      hs_prev = hsync;
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (line_start !== 1'b0) begin
          bad++;
          $display("FAIL line_start_width: got %b want 0", line_start);
        end
      end
      if (line_start === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || (cyc - c0) != 1600) begin
      bad++;
      $display("FAIL line_period: ok=%0d got %0d want 1600", ok, cyc - c0);
    end
    total++;
    if (hs_low != 192) begin
      bad++;
      $display("FAIL hsync_low: got %0d want 192", hs_low);
    end
    total++;
    if (fall_hpos != 657 || fall_stb != 0) begin
      bad++;
      $display("FAIL hsync_start: hpos=%0d stb=%0d want 657 0", fall_hpos, fall_stb);
    end
    total++;
    if (blank_err != 0 || rgb_hi != 1280) begin
      bad++;
      $display("FAIL rgb_blank_line: errs=%0d hi=%0d want 0 1280", blank_err, rgb_hi);
    end
  endtask

  task automatic test_frame();
    bit ok;
    int c0, vs_low, rgb_hi;
    @(negedge clk);
    rst_s   = 1'b0;
    c_rel_s = cyc;
    wait_fs_s(400, ok);
    total++;
    if (!ok || (cyc - c_rel_s) != 161 || frame_s !== 8'd1) begin
      bad++;
      $display("FAIL first_frame_start: ok=%0d cycle=%0d frame=%0d want 161 1",
               ok, cyc - c_rel_s, frame_s);
    end
    total++;
    if ({hpos_s, vpos_s, line_start_s} !== {20'd0, 1'b1}) begin
      bad++;
      $display("FAIL frame_wrap_pos: hpos=%0d vpos=%0d ls=%b want 0 0 1",
               hpos_s, vpos_s, line_start_s);
    end
    c0 = cyc; vs_low = 0; rgb_hi = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (vsync_s === 1'b0) vs_low++;
      if (rgb_out_s === 6'h3F) rgb_hi++;
      @(negedge clk);
      if (frame_start_s === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || (cyc - c0) != 160 || frame_s !== 8'd2) begin
      bad++;
      $display("FAIL frame_period: ok=%0d got %0d frame=%0d want 160 2",
               ok, cyc - c0, frame_s);
    end
    total++;
    if (vs_low != 32) begin
      bad++;
      $display("FAIL vsync_low: got %0d want 32", vs_low);
    end
    total++;
    if (rgb_hi != 48) begin
      bad++;
      $display("FAIL rgb_frame_active: got %0d want 48", rgb_hi);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int pulses;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (hpos_s == 10'd15 && vpos_s == 10'd7) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || vsync_s !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_pos: ok=%0d vsync=%b want 1 0", ok, vsync_s);
    end
    #1 rst_s = 1'b1;
    #1;
    total++;
    if ({pix_stb_s, line_start_s, frame_start_s, hsync_s, vsync_s, de_s,
         hpos_s, vpos_s, frame_s, rgb_out_s} !== {6'b000110, 34'd0}) begin
      bad++;
      $display("FAIL async_reset: stb=%b hs=%b vs=%b hpos=%0d vpos=%0d frame=%0d",
               pix_stb_s, hsync_s, vsync_s, hpos_s, vpos_s, frame_s);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (line_start_s !== 1'b0 || frame_start_s !== 1'b0 || hpos_s !== 10'd0) pulses++;
    end
    rst_s   = 1'b0;
    c_rel_s = cyc;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (line_start_s !== 1'b0 || frame_start_s !== 1'b0) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_no_pulse: got %0d glitches want 0", pulses);
    end
    wait_fs_s(400, ok);
    total++;
    if (!ok || (cyc - c_rel_s) != 161 || frame_s !== 8'd1) begin
      bad++;
      $display("FAIL restart_frame: ok=%0d cycle=%0d frame=%0d want 161 1",
               ok, cyc - c_rel_s, frame_s);
    end
  endtask

  task automatic test_frame_wrap();
    bit ok;
    int last, bad_per, f255, f256;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    last = cyc; bad_per = 0; f255 = -1; f256 = -1;
    for (int n = 1; n <= 256; n++) begin
      wait_fs_s(400, ok);
      if (!ok) begin bad_per++; break; end
      if (n > 1 && (cyc - last) != 160) bad_per++;
      last = cyc;
      if (n == 255) f255 = int'(frame_s);
      if (n == 256) f256 = int'(frame_s);
    end
    total++;
    if (bad_per != 0) begin
      bad++;
      $display("FAIL wrap_periods: got %0d irregular want 0", bad_per);
    end
    total++;
    if (f255 != 255 || f256 != 0) begin
      bad++;
      $display("FAIL frame_wrap: got %0d,%0d want 255,0", f255, f256);
    end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_line();
    test_frame();
    test_mid_reset();
    test_frame_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
